// File: rtl/morse_pkg.sv
// Shared FSM state type, segment constants and buffer depth for the Morse decoder.
// Segment bytes are active-high {dp, g, f, e, d, c, b, a}.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StGap,
        StCommit
    } morse_state_e;

    localparam int unsigned BufDepth = 8;

    localparam logic [7:0] SegBlank = 8'h00;
    localparam logic [7:0] SegErr   = 8'h40;

    localparam logic [7:0] SegA = 8'h77;
    localparam logic [7:0] SegB = 8'h7c;
    localparam logic [7:0] SegC = 8'h39;
    localparam logic [7:0] SegD = 8'h5e;
    localparam logic [7:0] SegE = 8'h79;
    localparam logic [7:0] SegF = 8'h71;
    localparam logic [7:0] SegG = 8'h3d;
    localparam logic [7:0] SegH = 8'h76;
    localparam logic [7:0] SegI = 8'h30;
    localparam logic [7:0] SegJ = 8'h1e;
    localparam logic [7:0] SegK = 8'h75;
    localparam logic [7:0] SegL = 8'h38;
    localparam logic [7:0] SegM = 8'h37;
    localparam logic [7:0] SegN = 8'h54;
    localparam logic [7:0] SegO = 8'h5c;
    localparam logic [7:0] SegP = 8'h73;
    localparam logic [7:0] SegQ = 8'h67;
    localparam logic [7:0] SegR = 8'h50;
    localparam logic [7:0] SegS = 8'h6d;
    localparam logic [7:0] SegT = 8'h78;
    localparam logic [7:0] SegU = 8'h3e;
    localparam logic [7:0] SegV = 8'h1c;
    localparam logic [7:0] SegW = 8'h2a;
    localparam logic [7:0] SegX = 8'h64;
    localparam logic [7:0] SegY = 8'h6e;
    localparam logic [7:0] SegZ = 8'h5b;

    localparam logic [7:0] Seg0 = 8'h3f;
    localparam logic [7:0] Seg1 = 8'h06;
    localparam logic [7:0] Seg2 = 8'h5b;
    localparam logic [7:0] Seg3 = 8'h4f;
    localparam logic [7:0] Seg4 = 8'h66;
    localparam logic [7:0] Seg5 = 8'h6d;
    localparam logic [7:0] Seg6 = 8'h7d;
    localparam logic [7:0] Seg7 = 8'h07;
    localparam logic [7:0] Seg8 = 8'h7f;
    localparam logic [7:0] Seg9 = 8'h6f;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code lookup: (length, pattern) -> {valid, segment byte}.
// Digits (5-symbol codes) decode only when MORSE_DIGITS_EN is defined.
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] len_i,
    input  logic [4:0] pat_i,
    output logic       valid_o,
    output logic [7:0] seg_o
);

    // First symbol sits in the MSB of the used field; dot = 0, dash = 1.
    always_comb begin
        valid_o = 1'b1;
        seg_o   = SegErr;
        case ({len_i, pat_i})
            {3'd1, 5'b00000}: seg_o = SegE;
            {3'd1, 5'b00001}: seg_o = SegT;
            {3'd2, 5'b00000}: seg_o = SegI;
            {3'd2, 5'b00001}: seg_o = SegA;
            {3'd2, 5'b00010}: seg_o = SegN;
            {3'd2, 5'b00011}: seg_o = SegM;
            {3'd3, 5'b00000}: seg_o = SegS;
            {3'd3, 5'b00001}: seg_o = SegU;
            {3'd3, 5'b00010}: seg_o = SegR;
            {3'd3, 5'b00011}: seg_o = SegW;
            {3'd3, 5'b00100}: seg_o = SegD;
            {3'd3, 5'b00101}: seg_o = SegK;
            {3'd3, 5'b00110}: seg_o = SegG;
            {3'd3, 5'b00111}: seg_o = SegO;
            {3'd4, 5'b00000}: seg_o = SegH;
            {3'd4, 5'b00001}: seg_o = SegV;
            {3'd4, 5'b00010}: seg_o = SegF;
            {3'd4, 5'b00100}: seg_o = SegL;
            {3'd4, 5'b00110}: seg_o = SegP;
            {3'd4, 5'b00111}: seg_o = SegJ;
            {3'd4, 5'b01000}: seg_o = SegB;
            {3'd4, 5'b01001}: seg_o = SegX;
            {3'd4, 5'b01010}: seg_o = SegC;
            {3'd4, 5'b01011}: seg_o = SegY;
            {3'd4, 5'b01100}: seg_o = SegZ;
            {3'd4, 5'b01101}: seg_o = SegQ;
`ifdef MORSE_DIGITS_EN
            {3'd5, 5'b11111}: seg_o = Seg0;
            {3'd5, 5'b01111}: seg_o = Seg1;
            {3'd5, 5'b00111}: seg_o = Seg2;
            {3'd5, 5'b00011}: seg_o = Seg3;
            {3'd5, 5'b00001}: seg_o = Seg4;
            {3'd5, 5'b00000}: seg_o = Seg5;
            {3'd5, 5'b10000}: seg_o = Seg6;
            {3'd5, 5'b11000}: seg_o = Seg7;
            {3'd5, 5'b11100}: seg_o = Seg8;
            {3'd5, 5'b11110}: seg_o = Seg9;
`endif
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_decoder_controller.sv
// Morse key decoder: times key presses/releases, decodes letters and keeps an
// 8-character segment display buffer. Define MORSE_DIGITS_EN to decode digits.
module morse_decoder_controller
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned DASH_TICKS = 30,
    parameter int unsigned GAP_TICKS  = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    key_in,
    input  logic                    backspace,
    output logic [8*BufDepth-1:0]   seg_dec,
    output logic [2:0]              sym_count,
    output logic                    err
);

    localparam int unsigned DivW   = $clog2(TICK_DIV + 1);
    localparam int unsigned PressW = $clog2(DASH_TICKS + 1);
    localparam int unsigned GapW   = $clog2(GAP_TICKS + 1);
    localparam int unsigned FillW  = $clog2(BufDepth + 1);
    localparam int unsigned SegW   = 8 * BufDepth;

    morse_state_e      state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [PressW-1:0] press_q, press_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [4:0]        sym_q, sym_d;
    logic [2:0]        len_q, len_d;
    logic              bad_q, bad_d;
    logic [SegW-1:0]   seg_q, seg_d;
    logic [FillW-1:0]  fill_q, fill_d;
    logic              err_q, err_d;
    logic              key_q, key_prev_q;
    logic              bs_q, bs_prev_q;

    logic              tick;
    logic              key_rise, key_fall, bs_rise;
    logic              lut_valid;
    logic [7:0]        lut_seg;
    logic [7:0]        push_seg;

    assign key_rise = en & key_q & ~key_prev_q;
    assign key_fall = en & ~key_q & key_prev_q;
    assign bs_rise  = en & bs_q & ~bs_prev_q;

    morse_lut u_lut (
        .len_i   (len_q),
        .pat_i   (sym_q),
        .valid_o (lut_valid),
        .seg_o   (lut_seg)
    );

    assign push_seg = (bad_q || !lut_valid) ? SegErr : lut_seg;

    always_comb begin
        div_d = div_q;
        tick  = 1'b0;
        if (en) begin
            if (div_q == DivW'(TICK_DIV - 1)) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + DivW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        press_d = press_q;
        gap_d   = gap_q;
        sym_d   = sym_q;
        len_d   = len_q;
        bad_d   = bad_q;
        seg_d   = seg_q;
        fill_d  = fill_q;
        err_d   = err_q;

        if (!en) begin
            state_d = StIdle;
            press_d = '0;
            gap_d   = '0;
            sym_d   = '0;
            len_d   = '0;
            bad_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (key_rise) begin
                        state_d = StPress;
                        press_d = '0;
                    end
                end
                StPress: begin
                    if (key_fall) begin
                        // A sixth symbol only poisons the letter; the held code is kept.
                        if (len_q == 3'd5) begin
                            bad_d = 1'b1;
                        end else begin
                            sym_d = {sym_q[3:0], (press_q == PressW'(DASH_TICKS))};
                            len_d = len_q + 3'd1;
                        end
                        state_d = StGap;
                        gap_d   = '0;
                    end else if (tick && press_q != PressW'(DASH_TICKS)) begin
                        press_d = press_q + PressW'(1);
                    end
                end
                StGap: begin
                    if (key_rise) begin
                        state_d = StPress;
                        press_d = '0;
                    end else if (tick) begin
                        if (gap_q == GapW'(GAP_TICKS - 1)) begin
                            state_d = StCommit;
                        end else begin
                            gap_d = gap_q + GapW'(1);
                        end
                    end
                end
                StCommit: begin
                    if (push_seg == SegErr) begin
                        err_d = 1'b1;
                    end
                    if (fill_q == FillW'(BufDepth)) begin
                        err_d = 1'b1;
                    end else begin
                        seg_d  = {seg_q[SegW-9:0], push_seg};
                        fill_d = fill_q + FillW'(1);
                    end
                    sym_d   = '0;
                    len_d   = '0;
                    bad_d   = 1'b0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            // Backspace acts on the post-commit buffer, so a same-cycle commit is undone.
            if (bs_rise) begin
                if (state_q == StPress || state_q == StGap) begin
                    state_d = StIdle;
                    press_d = '0;
                    gap_d   = '0;
                    sym_d   = '0;
                    len_d   = '0;
                    bad_d   = 1'b0;
                end else if (fill_d != '0) begin
                    seg_d  = {SegBlank, seg_d[SegW-1:8]};
                    fill_d = fill_d - FillW'(1);
                    err_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            press_q    <= '0;
            gap_q      <= '0;
            sym_q      <= '0;
            len_q      <= '0;
            bad_q      <= 1'b0;
            seg_q      <= '0;
            fill_q     <= '0;
            err_q      <= 1'b0;
            key_q      <= 1'b0;
            key_prev_q <= 1'b0;
            bs_q       <= 1'b0;
            bs_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            press_q    <= press_d;
            gap_q      <= gap_d;
            sym_q      <= sym_d;
            len_q      <= len_d;
            bad_q      <= bad_d;
            seg_q      <= seg_d;
            fill_q     <= fill_d;
            err_q      <= err_d;
            key_q      <= key_in;
            key_prev_q <= key_q;
            bs_q       <= backspace;
            bs_prev_q  <= bs_q;
        end
    end

    assign seg_dec   = seg_q;
    assign sym_count = len_q;
    assign err       = err_q;

endmodule
